count_capture_fifo: RTL and testbench
=====================================

Name: count_capture_fifo

Overview:
- Downstream consumer of the 8-bit event counter stage.
- Detects each rising edge of the counter's valid flag and captures the accompanying count value into a small FIFO.
- Presents captured values to the next stage through a valid/ready handshake.
- Keeps a sticky overflow flag and a saturating capture tally for debug readout.

Parameters:
- DATA_W, 8, width of captured counter value.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TALLY_W, 16, width of saturating accepted-capture tally.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- res_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: empties FIFO, clears overflow and tally.
- in_data  input  DATA_W  counter value from upstream counter.
- in_valid  input  1  counter valid flag (level); a capture fires on its 0->1 transition.
- out_data  output  DATA_W  FIFO head value.
- out_valid  output  1  head entry present.
- out_ready  input  1  downstream accepts head this cycle.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a capture was dropped because the FIFO was full.
- tally  output  TALLY_W  accepted captures, saturating at all-ones.

Behaviour:
- Reset (res_n low, asynchronous): out_valid=0, out_data=0, level=0, overflow=0, tally=0, pointers=0, edge register=0. Reset takes effect immediately, mid-operation included.
- Edge detect: a registered copy of in_valid is kept. push = in_valid & ~in_valid_q. A level held high gives exactly one capture. A 1-cycle pulse gives one capture.
- Push: in_data is sampled in the same cycle push is asserted.
  - Written at the next posedge.
  - Earliest out_valid is the cycle after the push edge (1-cycle latency, no bypass).
- Pop: pop = out_valid & out_ready; the head advances at the posedge.
  - out_data is a registered head value and is valid whenever out_valid=1.
  - out_data holds its last value when the FIFO is empty.
- out_valid = (level != 0). Data must not change while out_valid=1 and out_ready=0.
- Full (level==DEPTH):
  - Push without pop: the capture is dropped, overflow is set, and tally is unchanged.
  - Push with simultaneous pop: both happen, level stays DEPTH, no overflow.
- Empty (level==0): out_ready is ignored; pop is impossible.
- Pointers: $clog2(DEPTH) bits each, wrapping naturally modulo DEPTH. level is tracked explicitly.
- tally increments on each accepted push and saturates at 2^TALLY_W-1 with no wrap.
- clr:
  - Has priority over push and pop in the same cycle: level=0, pointers=0, overflow=0, tally=0.
  - The edge register still updates, so a level held across clr does not re-capture.
- overflow is cleared only by reset or clr.

Optional Feature:
- Macro: CAP_SYNC_EN.
- Defined:
  - in_valid passes through a 2-flop synchronizer before edge detection.
  - in_data is registered alongside so data and edge stay aligned.
  - Push latency grows by 2 cycles, so out_valid rises 3 cycles after the in_valid rise.
  - Use when the upstream counter runs off a non-clk event.
- Undefined: in_valid is treated as synchronous to clk; 1-cycle latency as above.

Decomposition:
- Package cap_pkg:
  - CAP_DATA_W default constant.
  - typedef cap_data_t (logic [DATA_W-1:0]).
  - Pointer-width function ptr_w(depth) = $clog2(depth).
- Sub-module cap_fifo_mem: DEPTH x DATA_W register array with write port (we, waddr, wdata) and registered read of raddr. Edge detect, pointers, flags and tally stay in the top level.

Test Plan:
- in_data=8'h05, in_valid 0->1 held 10 cycles -> exactly one entry; out_valid high 1 cycle after the rise; out_data=8'h05; tally=1.
- 4 pulses with values 1,2,3,4 and out_ready=0 -> level=4, overflow=0. A 5th pulse (value 5) -> level=4, overflow=1, tally=4. Draining yields 1,2,3,4 in order.
- FIFO full with out_ready=1 and a pulse (value 9) in the same cycle -> pop of head plus push of 9, level stays 4, overflow=0. The drain order ends with 9.
- tally preloaded by 65535 pushes (TALLY_W=16) -> one more push keeps tally=16'hFFFF.
- 3 entries queued, then res_n pulsed low asynchronously mid-cycle -> out_valid, level, overflow and tally are 0 immediately. clr asserted with a simultaneous push -> level=0, no entry stored.
- CAP_SYNC_EN defined: in_valid rise at cycle 0 with in_data=8'hA7 -> out_valid rises at cycle 3 and out_data=8'hA7.

Source files
------------

// File: rtl/cap_pkg.sv
// Shared constants, types and helpers for the count-capture FIFO.
package cap_pkg;

    localparam int CAP_DATA_W = 8;

    typedef logic [CAP_DATA_W-1:0] cap_data_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/count_capture_fifo_if.sv
// Capture input and downstream valid/ready output of count_capture_fifo, plus debug readout.
interface count_capture_fifo_if
    import cap_pkg::*;
#(
    parameter int DATA_W  = CAP_DATA_W,
    parameter int DEPTH   = 4,
    parameter int TALLY_W = 16
);
    localparam int LVL_W = ptr_w(DEPTH) + 1;

    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic [LVL_W-1:0]   level;
    logic               overflow;
    logic [TALLY_W-1:0] tally;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, level, overflow, tally
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, level, overflow, tally
    );

endinterface

// File: rtl/cap_fifo_mem.sv
// DEPTH x DATA_W storage with one write port and a registered read port that
// forwards same-cycle write data, so a push into an empty FIFO is visible one cycle later.
module cap_fifo_mem
    import cap_pkg::*;
#(
    parameter int DATA_W = CAP_DATA_W,
    parameter int DEPTH  = 4
)(
    input  logic                      clk,
    input  logic                      res_n,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      re,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the storage array has no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // NOTE: sequential state always uses non-blocking assignment.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)  rdata_q <= '0;
        else if (re) rdata_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/count_capture_fifo.sv
// Captures the count on each rising edge of in_valid into a small FIFO with sticky overflow and tally.
// Define CAP_SYNC_EN to pass in_valid/in_data through a 2-stage synchronizer first.
module count_capture_fifo
    import cap_pkg::*;
#(
    parameter int DATA_W  = CAP_DATA_W,
    parameter int DEPTH   = 4,
    parameter int TALLY_W = 16
)(
    input logic                 clk,
    input logic                 res_n,
    input logic                 clr,
    count_capture_fifo_if.slave bus
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic               cap_valid;
    logic [DATA_W-1:0]  cap_data;
    logic               edge_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overflow_q, overflow_d;
    logic [TALLY_W-1:0] tally_q, tally_d;
    logic               push, pop, full, push_ok;

`ifdef CAP_SYNC_EN
    logic              sync1_q, sync2_q;
    logic [DATA_W-1:0] data1_q, data2_q;

    // Data travels with the synchronized flag so the captured value matches its edge.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            sync1_q <= bus.in_valid;
            sync2_q <= sync1_q;
            data1_q <= bus.in_data;
            data2_q <= data1_q;
        end
    end

    assign cap_valid = sync2_q;
    assign cap_data  = data2_q;
`else
    assign cap_valid = bus.in_valid;
    assign cap_data  = bus.in_data;
`endif

    assign push    = cap_valid & ~edge_q;
    assign pop     = (level_q != '0) & bus.out_ready;
    assign full    = (level_q == LVL_W'(DEPTH));
    assign push_ok = push & (~full | pop);

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        tally_d    = tally_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            tally_d    = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (tally_q != '1) tally_d = tally_q + TALLY_W'(1);
            end
            if (pop)             rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            if (push & ~push_ok) overflow_d = 1'b1;
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    // The edge register keeps tracking through clr so a held level does not re-capture.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            edge_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tally_q    <= '0;
        end else begin
            edge_q     <= cap_valid;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            tally_q    <= tally_d;
        end
    end

    // The read register preloads the next head; it holds its value while the FIFO is empty.
    cap_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .res_n (res_n),
        .we    (push_ok & ~clr),
        .waddr (wr_ptr_q),
        .wdata (cap_data),
        .re    (level_d != '0),
        .raddr (rd_ptr_d),
        .rdata (bus.out_data)
    );

    assign bus.out_valid = (level_q != '0);
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;
    assign bus.tally     = tally_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Self-checking bench for count_capture_fifo: directed scenarios plus a randomized run
// against a queue-based reference model. A narrow tally keeps saturation reachable.
module tb_count_capture_fifo;
    import cap_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TW    = 6;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int TMAX  = (1 << TW) - 1;
`ifdef CAP_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = SYNC + 1;

    logic clk = 1'b0;
    logic res_n;
    logic clr;

    int total = 0;
    int bad   = 0;

    count_capture_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH), .TALLY_W(TW)) dut_if ();

    count_capture_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .TALLY_W(TW)) dut (
        .clk   (clk),
        .res_n (res_n),
        .clr   (clr),
        .bus   (dut_if.slave)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    cap_data_t m_q[$];
    logic      m_ovf;
    int        m_tally;
    cap_data_t m_data;
    logic      m_prev;
    logic      m_dl_v[$];
    cap_data_t m_dl_d[$];

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_tally = 0;
        m_data  = '0;
        m_prev  = 1'b0;
        m_dl_v.delete();
        m_dl_d.delete();
        for (int i = 0; i < SYNC; i++) begin
            m_dl_v.push_back(1'b0);
            m_dl_d.push_back('0);
        end
    endtask

    task automatic model_step(input logic v, input cap_data_t d, input logic rdy, input logic c);
        logic      ev, rise, pop, was_full;
        cap_data_t ed, tmp;
        m_dl_v.push_back(v);
        m_dl_d.push_back(d);
        ev = m_dl_v.pop_front();
        ed = m_dl_d.pop_front();
        rise   = ev && !m_prev;
        m_prev = ev;
        if (c) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_tally = 0;
        end else begin
            pop      = (m_q.size() != 0) && rdy;
            was_full = (m_q.size() == DEPTH);
            if (pop) tmp = m_q.pop_front();
            if (rise) begin
                if (!was_full || pop) begin
                    m_q.push_back(ed);
                    if (m_tally < TMAX) m_tally++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (m_q.size() != 0) m_data = m_q[0];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic v, input cap_data_t d, input logic rdy, input logic c);
        @(negedge clk);
        dut_if.in_valid  = v;
        dut_if.in_data   = d;
        dut_if.out_ready = rdy;
        clr              = c;
        model_step(v, d, rdy, c);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input cap_data_t d, input logic rdy);
        step(1'b1, d, rdy, 1'b0);
        step(1'b0, d, rdy, 1'b0);
    endtask

    task automatic settle(input logic rdy);
        repeat (LAT) step(1'b0, '0, rdy, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        res_n            = 1'b0;
        clr              = 1'b0;
        dut_if.in_valid  = 1'b0;
        dut_if.in_data   = '0;
        dut_if.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (dut_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", dut_if.out_valid); end
        total++; if (dut_if.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", dut_if.out_data); end
        total++; if (dut_if.level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", dut_if.level); end
        total++; if (dut_if.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", dut_if.overflow); end
        total++; if (dut_if.tally !== 6'd0) begin bad++; $display("FAIL reset_tally got=%0d want=0", dut_if.tally); end
        @(negedge clk);
        res_n = 1'b1;
    endtask

    task automatic test_held_level();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h05, 1'b0, 1'b0);
            total++;
            if (dut_if.out_valid !== (i >= LAT - 1)) begin
                bad++; $display("FAIL held_out_valid cycle=%0d got=%b want=%b", i, dut_if.out_valid, (i >= LAT - 1));
            end
        end
        total++; if (dut_if.level !== 3'd1) begin bad++; $display("FAIL held_level got=%0d want=1", dut_if.level); end
        total++; if (dut_if.out_data !== 8'h05) begin bad++; $display("FAIL held_out_data got=%h want=05", dut_if.out_data); end
        total++; if (dut_if.tally !== 6'd1) begin bad++; $display("FAIL held_tally got=%0d want=1", dut_if.tally); end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (dut_if.out_valid !== 1'b0) begin bad++; $display("FAIL held_drain_valid got=%b want=0", dut_if.out_valid); end
        total++; if (dut_if.out_data !== 8'h05) begin bad++; $display("FAIL held_data_hold got=%h want=05", dut_if.out_data); end
        settle(1'b0);
    endtask

    task automatic test_overflow();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int v = 1; v <= 4; v++) pulse(cap_data_t'(v), 1'b0);
        settle(1'b0);
        total++; if (dut_if.level !== 3'd4) begin bad++; $display("FAIL ovf_fill_level got=%0d want=4", dut_if.level); end
        total++; if (dut_if.overflow !== 1'b0) begin bad++; $display("FAIL ovf_fill_flag got=%b want=0", dut_if.overflow); end
        pulse(8'h05, 1'b0);
        settle(1'b0);
        total++; if (dut_if.level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d want=4", dut_if.level); end
        total++; if (dut_if.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", dut_if.overflow); end
        total++; if (dut_if.tally !== 6'd4) begin bad++; $display("FAIL ovf_tally got=%0d want=4", dut_if.tally); end
        // Holding out_ready low must freeze the head.
        step(1'b0, '0, 1'b0, 1'b0);
        total++; if (dut_if.out_data !== 8'h01) begin bad++; $display("FAIL ovf_stall_data got=%h want=01", dut_if.out_data); end
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (dut_if.out_valid !== 1'b1 || dut_if.out_data !== cap_data_t'(k)) begin
                bad++; $display("FAIL ovf_drain idx=%0d got=%b/%h want=1/%h", k, dut_if.out_valid, dut_if.out_data, cap_data_t'(k));
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        total++; if (dut_if.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", dut_if.out_valid); end
        total++; if (dut_if.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", dut_if.overflow); end
        // out_ready while empty must be ignored.
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (dut_if.level !== 3'd0) begin bad++; $display("FAIL ovf_empty_ready got=%0d want=0", dut_if.level); end
    endtask

    task automatic test_full_push_pop();
        cap_data_t exp_order [4] = '{8'h02, 8'h03, 8'h04, 8'h09};
        step(1'b0, '0, 1'b0, 1'b1);
        for (int v = 1; v <= 4; v++) pulse(cap_data_t'(v), 1'b0);
        settle(1'b0);
        for (int j = 0; j < LAT; j++) step((j == 0), 8'h09, (j == LAT - 1), 1'b0);
        total++; if (dut_if.level !== 3'd4) begin bad++; $display("FAIL fpp_level got=%0d want=4", dut_if.level); end
        total++; if (dut_if.overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%b want=0", dut_if.overflow); end
        total++; if (dut_if.tally !== 6'd5) begin bad++; $display("FAIL fpp_tally got=%0d want=5", dut_if.tally); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (dut_if.out_data !== exp_order[k]) begin
                bad++; $display("FAIL fpp_drain idx=%0d got=%h want=%h", k, dut_if.out_data, exp_order[k]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_saturate();
        step(1'b0, '0, 1'b1, 1'b1);
        for (int n = 1; n <= TMAX + 3; n++) begin
            pulse(cap_data_t'(n), 1'b1);
            if (n == TMAX - 1 || n == TMAX || n == TMAX + 3) begin
                settle(1'b1);
                total++;
                if (int'(dut_if.tally) != ((n < TMAX) ? n : TMAX)) begin
                    bad++; $display("FAIL sat_tally pushes=%0d got=%0d want=%0d", n, dut_if.tally, (n < TMAX) ? n : TMAX);
                end
            end
        end
        total++; if (dut_if.overflow !== 1'b0) begin bad++; $display("FAIL sat_overflow got=%b want=0", dut_if.overflow); end
    endtask

    task automatic test_async_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int v = 1; v <= 5; v++) pulse(cap_data_t'(8'h10 + v), 1'b0);
        settle(1'b0);
        total++; if (dut_if.overflow !== 1'b1) begin bad++; $display("FAIL arst_pre_ovf got=%b want=1", dut_if.overflow); end
        @(posedge clk);
        #3;
        res_n = 1'b0;
        #1;
        total++; if (dut_if.out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", dut_if.out_valid); end
        total++; if (dut_if.level !== 3'd0) begin bad++; $display("FAIL arst_level got=%0d want=0", dut_if.level); end
        total++; if (dut_if.overflow !== 1'b0) begin bad++; $display("FAIL arst_overflow got=%b want=0", dut_if.overflow); end
        total++; if (dut_if.tally !== 6'd0) begin bad++; $display("FAIL arst_tally got=%0d want=0", dut_if.tally); end
        total++; if (dut_if.out_data !== 8'h00) begin bad++; $display("FAIL arst_out_data got=%h want=00", dut_if.out_data); end
        dut_if.in_valid = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        model_reset();
    endtask

    task automatic test_clr_with_push();
        // in_valid rises and stays high; clr lands on the capture cycle.
        for (int j = 0; j < LAT; j++) step(1'b1, 8'h3C, 1'b0, (j == LAT - 1));
        total++; if (dut_if.level !== 3'd0) begin bad++; $display("FAIL clr_push_level got=%0d want=0", dut_if.level); end
        total++; if (dut_if.out_valid !== 1'b0) begin bad++; $display("FAIL clr_push_valid got=%b want=0", dut_if.out_valid); end
        total++; if (dut_if.tally !== 6'd0) begin bad++; $display("FAIL clr_push_tally got=%0d want=0", dut_if.tally); end
        repeat (3) step(1'b1, 8'h3C, 1'b0, 1'b0);
        total++; if (dut_if.level !== 3'd0) begin bad++; $display("FAIL clr_no_recapture got=%0d want=0", dut_if.level); end
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic v, rdy, c;
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 2) != 0);
            rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c   = ($urandom_range(0, 59) == 0);
            step(v, cap_data_t'($urandom), rdy, c);
            total++;
            if (dut_if.out_valid !== (m_q.size() != 0) || dut_if.level !== LW'(m_q.size()) ||
                dut_if.out_data !== m_data || dut_if.overflow !== m_ovf || dut_if.tally !== TW'(m_tally)) begin
                bad++;
                $display("FAIL rand cycle=%0d got v=%b lvl=%0d d=%h ovf=%b t=%0d want v=%b lvl=%0d d=%h ovf=%b t=%0d",
                         i, dut_if.out_valid, dut_if.level, dut_if.out_data, dut_if.overflow, dut_if.tally,
                         (m_q.size() != 0), m_q.size(), m_data, m_ovf, m_tally);
            end
        end
    endtask

    initial begin
        test_reset();
        test_held_level();
        test_overflow();
        test_full_push_pop();
        test_saturate();
        test_async_reset();
        test_clr_with_push();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
